// File: rtl/connect_n_pkg.sv
// Shared types and helpers for the connect-N game engine.
package connect_n_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ANIM   = 3'd1,
        S_COMMIT = 3'd2,
        S_SCAN   = 3'd3,
        S_OVER   = 3'd4
    } state_e;

    // Line directions: horizontal, vertical, diagonal "/" and diagonal "\".
    typedef enum logic [1:0] {
        DIR_H       = 2'd0,
        DIR_V       = 2'd1,
        DIR_DIAG_UP = 2'd2,
        DIR_DIAG_DN = 2'd3
    } dir_e;

    function automatic int dir_dx(input dir_e d);
        int r;
        r = (d == DIR_V) ? 0 : 1;
        return r;
    endfunction

    function automatic int dir_dy(input dir_e d);
        int r;
        case (d)
            DIR_H:       r = 0;
            DIR_V:       r = 1;
            DIR_DIAG_UP: r = 1;
            default:     r = -1;
        endcase
        return r;
    endfunction

    function automatic int unsigned idx(input int unsigned row, input int unsigned col,
                                        input int unsigned ncols);
        return row * ncols + col;
    endfunction

endpackage

// File: rtl/connect_n_engine_win_scanner.sv
// Sequential line scanner: walks outward from the placed cell in four directions.
module win_scanner
    import connect_n_pkg::*;
#(
    parameter int COLS    = 7,
    parameter int ROWS    = 6,
    parameter int WIN_LEN = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [COLS*ROWS-1:0]      board_i,
    input  logic [$clog2(ROWS)-1:0]   start_row_i,
    input  logic [$clog2(COLS)-1:0]   start_col_i,
    output logic                      done_o,
    output logic                      win_o,
    output logic [COLS*ROWS-1:0]      line_mask_o
);

    localparam int NC = COLS * ROWS;
    localparam int IW = $clog2(NC);
    localparam int PW = $clog2(((ROWS > COLS) ? ROWS : COLS) + 1) + 1;
    localparam int SW = $clog2(WIN_LEN);
    localparam int LW = $clog2(2 * WIN_LEN);

    logic                 active_q, done_q, win_q, sense_q;
    dir_e                 dir_q;
    logic signed [PW-1:0] r_q, c_q, sr_q, sc_q;
    logic [SW-1:0]        steps_q;
    logic [LW-1:0]        run_q, run_n;
    logic [IW-1:0]        home_q, start_idx, nidx;
    logic [NC-1:0]        mask_q, dmask_q, dmask_n;
    logic                 inb, hit, last_step, walk_end;
    int                   dx, dy, nr, nc;

    always_comb begin
        dx = dir_dx(dir_q);
        dy = dir_dy(dir_q);
        if (sense_q) begin
            dx = -dx;
            dy = -dy;
        end
        nr        = int'(r_q) + dy;
        nc        = int'(c_q) + dx;
        inb       = (nr >= 0) && (nr < ROWS) && (nc >= 0) && (nc < COLS);
        nidx      = IW'(idx(unsigned'(nr), unsigned'(nc), COLS));
        start_idx = IW'(idx(start_row_i, start_col_i, COLS));
        hit       = inb && board_i[nidx];
        // A walk also ends on the accepting step that reaches WIN_LEN-1 cells.
        last_step = hit && (int'(steps_q) == WIN_LEN - 2);
        walk_end  = !hit || last_step;
        dmask_n   = hit ? (dmask_q | (NC'(1) << nidx)) : dmask_q;
        run_n     = hit ? (run_q + LW'(1)) : run_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            done_q   <= 1'b0;
            win_q    <= 1'b0;
            sense_q  <= 1'b0;
            dir_q    <= DIR_H;
            r_q      <= '0;
            c_q      <= '0;
            sr_q     <= '0;
            sc_q     <= '0;
            steps_q  <= '0;
            run_q    <= '0;
            home_q   <= '0;
            mask_q   <= '0;
            dmask_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                active_q <= 1'b1;
                win_q    <= 1'b0;
                mask_q   <= '0;
                dir_q    <= DIR_H;
                sense_q  <= 1'b0;
                r_q      <= PW'(start_row_i);
                c_q      <= PW'(start_col_i);
                sr_q     <= PW'(start_row_i);
                sc_q     <= PW'(start_col_i);
                home_q   <= start_idx;
                steps_q  <= '0;
                run_q    <= LW'(1);
                dmask_q  <= NC'(1) << start_idx;
            end else if (active_q) begin
                if (!walk_end) begin
                    r_q     <= PW'(nr);
                    c_q     <= PW'(nc);
                    steps_q <= steps_q + SW'(1);
                    run_q   <= run_n;
                    dmask_q <= dmask_n;
                end else if (!sense_q) begin
                    sense_q <= 1'b1;
                    r_q     <= sr_q;
                    c_q     <= sc_q;
                    steps_q <= '0;
                    run_q   <= run_n;
                    dmask_q <= dmask_n;
                end else begin
                    if (int'(run_n) >= WIN_LEN) begin
                        win_q  <= 1'b1;
                        mask_q <= mask_q | dmask_n;
                    end
                    if (dir_q == DIR_DIAG_DN) begin
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        dir_q   <= dir_e'(dir_q + 2'd1);
                        sense_q <= 1'b0;
                        r_q     <= sr_q;
                        c_q     <= sc_q;
                        steps_q <= '0;
                        run_q   <= LW'(1);
                        dmask_q <= NC'(1) << home_q;
                    end
                end
            end
        end
    end

    assign done_o      = done_q;
    assign win_o       = win_q;
    assign line_mask_o = mask_q;

endmodule

// File: rtl/connect_n_engine.sv
// Connect-N game engine: cursor, fills, bitboards, drop animation and win detection.
module connect_n_engine
    import connect_n_pkg::*;
#(
    parameter int COLS     = 7,
    parameter int ROWS     = 6,
    parameter int WIN_LEN  = 4,
    parameter int ANIM_DIV = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_tick,
    input  logic                    left,
    input  logic                    right,
    input  logic                    put,
    output logic [$clog2(COLS)-1:0] selected_col,
    output logic                    which_player,
    output logic [COLS*ROWS-1:0]    color_p0,
    output logic [COLS*ROWS-1:0]    color_p1,
    output logic                    anim_active,
    output logic [$clog2(COLS)-1:0] anim_col,
    output logic [$clog2(ROWS)-1:0] anim_row,
    output logic                    anim_player,
    output logic                    invalid_detect,
    output logic                    win_valid,
    output logic                    victor,
    output logic [COLS*ROWS-1:0]    winner_tokens,
    output logic                    full_panel,
    output logic                    busy
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int NC = COLS * ROWS;
    localparam int IW = $clog2(NC);
    localparam int FW = $clog2(ROWS + 1);
    localparam int TW = $clog2(NC + 1);
    localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] sel_q, sel_d, acol_q, acol_d;
    logic [RW-1:0] arow_q, arow_d, target_q, target_d;
    logic          player_q, player_d, aplayer_q, aplayer_d;
    logic [NC-1:0] p0_q, p0_d, p1_q, p1_d, wmask_q, wmask_d;
    logic [FW-1:0] fill_q [COLS];
    logic [FW-1:0] fill_d [COLS];
    logic [TW-1:0] total_q, total_d;
    logic [DW-1:0] div_q, div_d;
    logic          invalid_q, invalid_d, win_q, win_d, victor_q, victor_d, full_q, full_d;
    logic          scan_start, scan_done, scan_win;
    logic [NC-1:0] scan_mask, scan_board;
    logic [IW-1:0] commit_pos;

    assign scan_board = aplayer_q ? p1_q : p0_q;

    win_scanner #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .WIN_LEN (WIN_LEN)
    ) u_scan (
        .clk         (clk),
        .rst         (rst),
        .start_i     (scan_start),
        .board_i     (scan_board),
        .start_row_i (target_q),
        .start_col_i (acol_q),
        .done_o      (scan_done),
        .win_o       (scan_win),
        .line_mask_o (scan_mask)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        player_d   = player_q;
        p0_d       = p0_q;
        p1_d       = p1_q;
        fill_d     = fill_q;
        total_d    = total_q;
        acol_d     = acol_q;
        arow_d     = arow_q;
        aplayer_d  = aplayer_q;
        target_d   = target_q;
        div_d      = div_q;
        invalid_d  = invalid_q;
        win_d      = win_q;
        victor_d   = victor_q;
        wmask_d    = wmask_q;
        full_d     = full_q;
        scan_start = 1'b0;
        commit_pos = IW'(idx(target_q, acol_q, COLS));
        unique case (state_q)
            S_IDLE: begin
                if (put) begin
                    if (fill_q[sel_q] == FW'(ROWS)) begin
                        invalid_d = 1'b1;
                    end else begin
                        invalid_d = 1'b0;
                        acol_d    = sel_q;
                        aplayer_d = player_q;
                        target_d  = RW'(fill_q[sel_q]);
                        arow_d    = RW'(ROWS - 1);
                        div_d     = '0;
                        state_d   = S_ANIM;
                    end
                end else if (left) begin
                    invalid_d = 1'b0;
                    sel_d     = (sel_q == '0) ? CW'(COLS - 1) : sel_q - CW'(1);
                end else if (right) begin
                    invalid_d = 1'b0;
                    sel_d     = (sel_q == CW'(COLS - 1)) ? '0 : sel_q + CW'(1);
                end
            end
            S_ANIM: begin
                if (frame_tick) begin
                    if (div_q == DW'(ANIM_DIV - 1)) begin
                        div_d = '0;
                        if (arow_q > target_q) arow_d = arow_q - RW'(1);
                        else                   state_d = S_COMMIT;
                    end else begin
                        div_d = div_q + DW'(1);
                    end
                end
            end
            S_COMMIT: begin
                if (aplayer_q) p1_d = p1_q | (NC'(1) << commit_pos);
                else           p0_d = p0_q | (NC'(1) << commit_pos);
                fill_d[acol_q] = fill_q[acol_q] + FW'(1);
                total_d        = total_q + TW'(1);
                scan_start     = 1'b1;
                state_d        = S_SCAN;
            end
            S_SCAN: begin
                if (scan_done) begin
                    if (scan_win) begin
                        win_d    = 1'b1;
                        victor_d = aplayer_q;
                        wmask_d  = wmask_q | scan_mask;
                        state_d  = S_OVER;
                    end else if (total_q == TW'(NC)) begin
                        full_d  = 1'b1;
                        state_d = S_OVER;
                    end else begin
                        player_d = ~player_q;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_OVER: begin
                if (put) begin
                    p0_d      = '0;
                    p1_d      = '0;
                    total_d   = '0;
                    win_d     = 1'b0;
                    victor_d  = 1'b0;
                    wmask_d   = '0;
                    full_d    = 1'b0;
                    invalid_d = 1'b0;
                    player_d  = 1'b0;
                    for (int unsigned i = 0; i < COLS; i++) fill_d[i] = '0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            player_q  <= 1'b0;
            p0_q      <= '0;
            p1_q      <= '0;
            total_q   <= '0;
            acol_q    <= '0;
            arow_q    <= '0;
            aplayer_q <= 1'b0;
            target_q  <= '0;
            div_q     <= '0;
            invalid_q <= 1'b0;
            win_q     <= 1'b0;
            victor_q  <= 1'b0;
            wmask_q   <= '0;
            full_q    <= 1'b0;
            for (int unsigned i = 0; i < COLS; i++) fill_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            player_q  <= player_d;
            p0_q      <= p0_d;
            p1_q      <= p1_d;
            total_q   <= total_d;
            acol_q    <= acol_d;
            arow_q    <= arow_d;
            aplayer_q <= aplayer_d;
            target_q  <= target_d;
            div_q     <= div_d;
            invalid_q <= invalid_d;
            win_q     <= win_d;
            victor_q  <= victor_d;
            wmask_q   <= wmask_d;
            full_q    <= full_d;
            fill_q    <= fill_d;
        end
    end

    assign selected_col   = sel_q;
    assign which_player   = player_q;
    assign color_p0       = p0_q;
    assign color_p1       = p1_q;
    assign anim_active    = (state_q == S_ANIM);
    assign anim_col       = acol_q;
    assign anim_row       = arow_q;
    assign anim_player    = aplayer_q;
    assign invalid_detect = invalid_q;
    assign win_valid      = win_q;
    assign victor         = victor_q;
    assign winner_tokens  = wmask_q;
    assign full_panel     = full_q;
    assign busy           = (state_q != S_IDLE) && (state_q != S_OVER);

endmodule

// File: tb/tb_connect_n_engine.sv
// Directed bench for connect_n_engine on a 7x6 board, 4 in a row, one frame per row step.
module tb_connect_n_engine;

    localparam int COLS     = 7;
    localparam int ROWS     = 6;
    localparam int WIN_LEN  = 4;
    localparam int ANIM_DIV = 1;
    localparam int NC       = COLS * ROWS;

    logic          clk = 1'b0, rst = 1'b1, frame_tick = 1'b0;
    logic          left = 1'b0, right = 1'b0, put = 1'b0;
    logic [2:0]    selected_col, anim_col, anim_row;
    logic          which_player, anim_active, anim_player, invalid_detect;
    logic          win_valid, victor, full_panel, busy;
    logic [NC-1:0] color_p0, color_p1, winner_tokens;

    int vec  = 0;
    int errs = 0;

    connect_n_engine #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .WIN_LEN  (WIN_LEN),
        .ANIM_DIV (ANIM_DIV)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_tick     (frame_tick),
        .left           (left),
        .right          (right),
        .put            (put),
        .selected_col   (selected_col),
        .which_player   (which_player),
        .color_p0       (color_p0),
        .color_p1       (color_p1),
        .anim_active    (anim_active),
        .anim_col       (anim_col),
        .anim_row       (anim_row),
        .anim_player    (anim_player),
        .invalid_detect (invalid_detect),
        .win_valid      (win_valid),
        .victor         (victor),
        .winner_tokens  (winner_tokens),
        .full_panel     (full_panel),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_put();   put   = 1'b1; cyc(); put   = 1'b0; endtask
    task automatic pulse_left();  left  = 1'b1; cyc(); left  = 1'b0; endtask
    task automatic pulse_right(); right = 1'b1; cyc(); right = 1'b0; endtask
    task automatic ftick();       frame_tick = 1'b1; cyc(); frame_tick = 1'b0; endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic goto_col(input int c);
        for (int i = 0; i < 2 * COLS && int'(selected_col) != c; i++) pulse_right();
    endtask

    task automatic finish_move();
        for (int n = 0; n < 200 && busy; n++) ftick();
        chk("move_done", 64'(busy), 64'd0);
    endtask

    task automatic drop(input int c);
        goto_col(c);
        pulse_put();
        finish_move();
    endtask

    int            win_cols  [7]  = '{0, 6, 1, 6, 2, 6, 3};
    int            diag_cols [11] = '{3, 2, 2, 1, 0, 1, 1, 0, 6, 0, 0};
    int            g         [7]  = '{0, 0, 1, 1, 0, 0, 1};
    int            pair_b    [3]  = '{0, 1, 4};
    int            pair_a    [3]  = '{2, 3, 6};
    int            lat;
    logic [NC-1:0] exp_p0, exp_p1;

    initial begin
        do_reset();
        chk("rst_sel",      64'(selected_col),   64'd0);
        chk("rst_player",   64'(which_player),   64'd0);
        chk("rst_p0",       64'(color_p0),       64'd0);
        chk("rst_p1",       64'(color_p1),       64'd0);
        chk("rst_anim",     64'(anim_active),    64'd0);
        chk("rst_invalid",  64'(invalid_detect), 64'd0);
        chk("rst_win",      64'(win_valid),      64'd0);
        chk("rst_wmask",    64'(winner_tokens),  64'd0);
        chk("rst_full",     64'(full_panel),     64'd0);
        chk("rst_busy",     64'(busy),           64'd0);

        pulse_left();
        chk("left_wrap", 64'(selected_col), 64'd6);
        pulse_right();
        chk("right_wrap", 64'(selected_col), 64'd0);
        pulse_right();
        chk("right_1", 64'(selected_col), 64'd1);

        goto_col(3);
        pulse_put();
        chk("anim_on",     64'(anim_active), 64'd1);
        chk("anim_col",    64'(anim_col),    64'd3);
        chk("anim_player", 64'(anim_player), 64'd0);
        chk("anim_busy",   64'(busy),        64'd1);
        for (int r = 5; r >= 0; r--) begin
            chk("anim_row", 64'(anim_row), 64'(r));
            ftick();
        end
        chk("anim_off", 64'(anim_active), 64'd0);
        finish_move();
        chk("drop1_p0",     64'(color_p0),     64'h8);
        chk("drop1_p1",     64'(color_p1),     64'd0);
        chk("drop1_player", 64'(which_player), 64'd1);

        // Horizontal win for player 0 along the bottom row.
        do_reset();
        foreach (win_cols[i]) drop(win_cols[i]);
        chk("hwin_valid",  64'(win_valid),     64'd1);
        chk("hwin_victor", 64'(victor),        64'd0);
        chk("hwin_mask",   64'(winner_tokens), 64'hF);
        chk("hwin_p0",     64'(color_p0),      64'hF);
        chk("hwin_p1",     64'(color_p1),      64'h102040);
        chk("hwin_full",   64'(full_panel),    64'd0);
        pulse_left();
        chk("over_left_ignored", 64'(selected_col), 64'd3);
        pulse_put();
        chk("restart_p0",     64'(color_p0),      64'd0);
        chk("restart_p1",     64'(color_p1),      64'd0);
        chk("restart_win",    64'(win_valid),     64'd0);
        chk("restart_wmask",  64'(winner_tokens), 64'd0);
        chk("restart_player", 64'(which_player),  64'd0);
        chk("restart_sel",    64'(selected_col),  64'd3);

        for (int i = 0; i < 6; i++) drop(2);
        chk("col2_p0", 64'(color_p0), 64'h40010004);
        chk("col2_p1", 64'(color_p1), 64'h2000800200);
        pulse_put();
        chk("full_col_invalid", 64'(invalid_detect), 64'd1);
        chk("full_col_noanim",  64'(anim_active),    64'd0);
        chk("full_col_busy",    64'(busy),           64'd0);
        chk("full_col_player",  64'(which_player),   64'd0);
        pulse_right();
        chk("invalid_cleared", 64'(invalid_detect), 64'd0);
        chk("invalid_sel",     64'(selected_col),   64'd3);

        // Diagonal "\" win: (3,0) (2,1) (1,2) (0,3) for player 0.
        do_reset();
        for (int i = 0; i < 10; i++) drop(diag_cols[i]);
        chk("diag_pre_win", 64'(win_valid), 64'd0);
        goto_col(diag_cols[10]);
        pulse_put();
        for (int n = 0; n < 20 && anim_active; n++) ftick();
        chk("diag_commit", 64'(anim_active), 64'd0);
        lat = 0;
        while (busy && lat < 100) begin
            cyc();
            lat++;
        end
        chk("scan_latency", 64'(lat <= 26), 64'd1);
        chk("dwin_valid",  64'(win_valid),     64'd1);
        chk("dwin_victor", 64'(victor),        64'd0);
        chk("dwin_mask",   64'(winner_tokens), 64'h208208);

        // Draw: owner(r,c) = (r + g[c]) mod 2, built from interleaved column pairs.
        pulse_put();
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 12; i++)
                drop(((i % 4) == 1 || (i % 4) == 2) ? pair_a[p] : pair_b[p]);
        for (int i = 0; i < 6; i++) drop(5);
        exp_p0 = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (((r + g[c]) % 2) == 0) exp_p0[r*COLS+c] = 1'b1;
        exp_p1 = ~exp_p0;
        chk("draw_full",   64'(full_panel),    64'd1);
        chk("draw_win",    64'(win_valid),     64'd0);
        chk("draw_wmask",  64'(winner_tokens), 64'd0);
        chk("draw_p0",     64'(color_p0),      64'(exp_p0));
        chk("draw_p1",     64'(color_p1),      64'(exp_p1));
        chk("draw_player", 64'(which_player),  64'd1);

        pulse_put();
        drop(0);
        goto_col(1);
        pulse_put();
        ftick();
        chk("pre_rst_anim", 64'(anim_active), 64'd1);
        rst = 1'b1;
        cyc();
        chk("midrst_p0",   64'(color_p0),    64'd0);
        chk("midrst_p1",   64'(color_p1),    64'd0);
        chk("midrst_anim", 64'(anim_active), 64'd0);
        chk("midrst_busy", 64'(busy),        64'd0);
        rst = 1'b0;
        cyc();

        left = 1'b1;
        put  = 1'b1;
        cyc();
        left = 1'b0;
        put  = 1'b0;
        chk("prio_put_anim", 64'(anim_active),  64'd1);
        chk("prio_put_sel",  64'(selected_col), 64'd0);
        finish_move();
        left  = 1'b1;
        right = 1'b1;
        cyc();
        left  = 1'b0;
        right = 1'b0;
        chk("prio_left_sel", 64'(selected_col), 64'd6);
        chk("post_rst_p0",   64'(color_p0),     64'h1);
        chk("post_rst_p1",   64'(color_p1),     64'd0);
        chk("post_rst_plyr", 64'(which_player), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/connect_n_engine.md
Name: connect_n_engine

Overview:
- Parametrised game-state engine for the connect-style board: C columns × R rows, win length K, replacing the fixed 7×6/4-in-a-row game FSM.
- Owns the cursor, the per-column fill counters and the two player bitboards.
- Drives the frame-paced drop animation and detects wins with a sequential line scanner.
- Sits between the debounced button pulses and the VGA display; its outputs feed the renderer directly.

Parameters:
- COLS, 7, board columns (2..16)
- ROWS, 6, board rows (2..16)
- WIN_LEN, 4, tokens in a line needed to win (2..min(COLS,ROWS)... but at least 2)
- ANIM_DIV, 2, frame_ticks per one-row animation step (≥1)

Ports:
- clk  in  1  system (VGA) clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- left  in  1  one-cycle pulse: cursor left
- right  in  1  one-cycle pulse: cursor right
- put  in  1  one-cycle pulse: drop token / restart after game over
- selected_col  out  CW=$clog2(COLS)  cursor column
- which_player  out  1  player to move (0/1)
- color_p0  out  COLS*ROWS  player-0 bitboard; index = row*COLS+col, row 0 = bottom
- color_p1  out  COLS*ROWS  player-1 bitboard, same indexing
- anim_active  out  1  drop animation in progress
- anim_col  out  CW  animating column
- anim_row  out  RW=$clog2(ROWS)  current animated row
- anim_player  out  1  owner of the animating token
- invalid_detect  out  1  last put targeted a full column
- win_valid  out  1  game ended with a winner
- victor  out  1  winning player (valid when win_valid)
- winner_tokens  out  COLS*ROWS  mask of the winning line cells
- full_panel  out  1  board full with no winner (draw)
- busy  out  1  state ≠ IDLE and ≠ OVER

Behaviour:
- Reset: all outputs 0, fill counters 0, state IDLE.
- States:
  - IDLE: accepts left, right and put.
  - ANIM → COMMIT → SCAN → IDLE or OVER.
  - OVER: only put is accepted.
- Pulse priority in IDLE on the same cycle: put > left > right. Inputs outside IDLE/OVER are ignored.
- Cursor:
  - left at col 0 wraps to COLS-1; right at COLS-1 wraps to 0. Takes effect on the next cycle.
  - Any accepted left, right or put clears invalid_detect.
- put when fill[selected_col] == ROWS: set invalid_detect (held), no state change.
- Valid put:
  - Latch anim_col = selected_col, anim_player = which_player, target = fill[col].
  - anim_row = ROWS-1, anim_active = 1, go to ANIM.
- ANIM:
  - Every ANIM_DIV frame_ticks: if anim_row > target, anim_row decrements; else go to COMMIT.
  - Top-row target (target = ROWS-1) therefore takes exactly ANIM_DIV frames.
- COMMIT (1 cycle):
  - Set bit target*COLS+anim_col in the owner's bitboard; fill[col]++.
  - anim_active = 0; start the scanner.
- SCAN (win_scanner):
  - For each of 4 directions (H, V, diag /, diag \), walk outward from the placed cell both ways, one cell per clock.
  - A walk stops at the board edge, at a non-owner cell, or after WIN_LEN-1 steps.
  - Run = 1 + both walks; a direction wins if run ≥ WIN_LEN.
  - Latency ≤ 8·(WIN_LEN-1)+2 cycles.
  - Winning-direction cells are OR-ed into winner_tokens; multiple winning directions all contribute.
- After SCAN:
  - win: win_valid = 1, victor = anim_player, go to OVER.
  - else, total tokens == COLS*ROWS: full_panel = 1, go to OVER.
  - else: toggle which_player, go to IDLE.
- OVER + put: clear the bitboards, fills, winner flags and masks; which_player = 0; cursor kept; go to IDLE.
- rst mid-ANIM or mid-SCAN: immediate clear; no partial commit survives.
- Total token counter width: $clog2(COLS*ROWS+1).

Decomposition:
- Package connect_n_pkg holds:
  - state enum (IDLE, ANIM, COMMIT, SCAN, OVER)
  - direction enum and dx/dy constant function
  - cell-index function idx(row,col,COLS)
- One sub-module, win_scanner:
  - Inputs: owner bitboard, start row/col, start pulse.
  - Outputs: done, win, line mask.
  - Parameterised by COLS/ROWS/WIN_LEN.

Test Plan (COLS=7, ROWS=6, WIN_LEN=4, ANIM_DIV=1):
- Reset, then left ×1 → selected_col=6; right ×2 → selected_col=1.
- put on col 3, empty board → anim_row steps 5,4,3,2,1,0 on successive frame_ticks. Then color_p0 bit 3 set, which_player=1, busy low.
- Alternate puts cols 0,6,1,6,2,6,3 → win_valid=1, victor=0, winner_tokens = bits 0..3 only. A further left is ignored; put restarts with color_p0=0.
- 6 puts in col 2, then a 7th put → invalid_detect=1, no animation; next right clears it.
- Diagonal "\" win built from mixed columns → winner_tokens has exactly 4 bits along the diagonal; scan completes within 26 cycles of COMMIT.
- Drawn 42-token fill sequence → full_panel=1, win_valid=0. Assert rst during ANIM of a separate game → all bitboards 0 the next cycle.
